// File: rtl/featuremap_accum.sv
// Cross-channel accumulator: sums N_CH interleaved partials per pixel, adds bias,
// optional ReLU, saturates to DATA_WIDTH and presents one pixel with frame tracking.
module featuremap_accum #(
    parameter int DATA_WIDTH   = 24,
    parameter int N_CH         = 6,
    parameter int BIAS         = 0,
    parameter int ACT_MODE     = 0,
    parameter int FRAME_PIXELS = 576
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  out_ready,
    output logic                  frame_done
);
    localparam int AW = DATA_WIDTH + $clog2(N_CH) + 1;
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [CW-1:0] CH_LAST  = CW'(N_CH - 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(FRAME_PIXELS - 1);
    localparam logic [DATA_WIDTH-1:0] BIAS_RAW = DATA_WIDTH'(BIAS);
    localparam logic [AW-1:0] BIAS_EXT = {{(AW-DATA_WIDTH){BIAS_RAW[DATA_WIDTH-1]}}, BIAS_RAW};
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [AW-1:0]         acc_reg, acc_next;
    logic [CW-1:0]         ch_cnt_reg, ch_cnt_next;
    logic [PW-1:0]         pix_cnt_reg, pix_cnt_next;
    logic [DATA_WIDTH-1:0] data_out_reg, data_out_next;
    logic                  valid_out_reg, valid_out_next;
    logic                  frame_done_reg, frame_done_next;

    logic                  take;
    logic                  last_ch;
    logic [AW-1:0]         x_ext;
    logic [AW-1:0]         partial;
    logic [AW-1:0]         biased;
    logic [AW-1:0]         activated;
    logic [AW-DATA_WIDTH:0] top_bits;
    logic [DATA_WIDTH-1:0] sat_val;

    // A clear cycle refuses the sample so the upstream handshake stays honest.
    assign in_ready = rst & ~clear & ~(valid_out_reg & ~out_ready);
    assign take     = valid_in & in_ready;
    assign last_ch  = (ch_cnt_reg == CH_LAST);

    assign x_ext     = {{(AW-DATA_WIDTH){data_in[DATA_WIDTH-1]}}, data_in};
    assign partial   = (ch_cnt_reg == '0) ? x_ext : acc_reg + x_ext;
    assign biased    = partial + BIAS_EXT;
    assign activated = (ACT_MODE == 1 && biased[AW-1]) ? '0 : biased;

    // In range exactly when every bit above the output sign bit matches it.
    assign top_bits = activated[AW-1:DATA_WIDTH-1];
    always_comb begin
        sat_val = activated[DATA_WIDTH-1:0];
        if (!(&top_bits) && (|top_bits)) begin
            sat_val = activated[AW-1] ? SAT_MIN : SAT_MAX;
        end
    end

    always_comb begin
        acc_next        = acc_reg;
        ch_cnt_next     = ch_cnt_reg;
        pix_cnt_next    = pix_cnt_reg;
        data_out_next   = data_out_reg;
        valid_out_next  = valid_out_reg;
        frame_done_next = frame_done_reg;

        if (valid_out_reg && out_ready) begin
            valid_out_next  = 1'b0;
            frame_done_next = 1'b0;
        end

        if (clear) begin
            acc_next     = '0;
            ch_cnt_next  = '0;
            pix_cnt_next = '0;
        end else if (take) begin
            if (last_ch) begin
                ch_cnt_next     = '0;
                data_out_next   = sat_val;
                valid_out_next  = 1'b1;
                frame_done_next = (pix_cnt_reg == PIX_LAST);
                pix_cnt_next    = (pix_cnt_reg == PIX_LAST) ? '0 : pix_cnt_reg + 1'b1;
            end else begin
                acc_next    = partial;
                ch_cnt_next = ch_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_reg        <= '0;
            ch_cnt_reg     <= '0;
            pix_cnt_reg    <= '0;
            data_out_reg   <= '0;
            valid_out_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            acc_reg        <= acc_next;
            ch_cnt_reg     <= ch_cnt_next;
            pix_cnt_reg    <= pix_cnt_next;
            data_out_reg   <= data_out_next;
            valid_out_reg  <= valid_out_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign data_out   = data_out_reg;
    assign valid_out  = valid_out_reg;
    assign frame_done = frame_done_reg;
endmodule

// File: tb/tb_featuremap_accum.sv
// Scoreboard bench: stimulus pushes hand-computed pixels, per-instance monitors
// pop and compare on every output transfer.
`timescale 1ns/1ps
module tb_featuremap_accum;
    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic signed [23:0] data_in;
    logic valid_in, valid_b;
    logic out_ready;

    logic        in_ready0, in_ready1, in_ready2;
    logic [23:0] data_out0, data_out1, data_out2;
    logic        valid_out0, valid_out1, valid_out2;
    logic        frame_done0, frame_done1, frame_done2;

    typedef struct {
        logic [23:0] d;
        logic        fd;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int exp_pix = 0;
    bit lat_chk = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    featuremap_accum #(.DATA_WIDTH(24), .N_CH(6), .BIAS(0), .ACT_MODE(0), .FRAME_PIXELS(4)) u0 (
        .clk(clk), .rst(rst), .clear(clear), .data_in(data_in), .valid_in(valid_in),
        .in_ready(in_ready0), .data_out(data_out0), .valid_out(valid_out0),
        .out_ready(out_ready), .frame_done(frame_done0));

    featuremap_accum #(.DATA_WIDTH(24), .N_CH(6), .BIAS(5), .ACT_MODE(0), .FRAME_PIXELS(4)) u1 (
        .clk(clk), .rst(rst), .clear(clear), .data_in(data_in), .valid_in(valid_b),
        .in_ready(in_ready1), .data_out(data_out1), .valid_out(valid_out1),
        .out_ready(out_ready), .frame_done(frame_done1));

    featuremap_accum #(.DATA_WIDTH(24), .N_CH(6), .BIAS(5), .ACT_MODE(1), .FRAME_PIXELS(4)) u2 (
        .clk(clk), .rst(rst), .clear(clear), .data_in(data_in), .valid_in(valid_b),
        .in_ready(in_ready2), .data_out(data_out2), .valid_out(valid_out2),
        .out_ready(out_ready), .frame_done(frame_done2));

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic mon(input int id, input logic [23:0] d, input logic fd);
        exp_t e;
        int   sz;
        sz = (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
        n_cmp++;
        if (sz == 0) begin
            n_bad++;
            $display("FAIL u%0d_unexpected: got data_out=%h frame_done=%b at cycle %0d, required no output",
                     id, d, fd, cyc);
        end else begin
            case (id)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            if (d !== e.d || fd !== e.fd || (e.cyc >= 0 && e.cyc != cyc)) begin
                n_bad++;
                $display("FAIL u%0d_pixel: got data_out=%h frame_done=%b cycle=%0d, required %h %b cycle=%0d",
                         id, d, fd, cyc, e.d, e.fd, e.cyc);
            end else begin
                $display("u%0d pixel data_out=%h frame_done=%b cycle=%0d ok", id, d, fd, cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst && out_ready) begin
            if (valid_out0) mon(0, data_out0, frame_done0);
            if (valid_out1) mon(1, data_out1, frame_done1);
            if (valid_out2) mon(2, data_out2, frame_done2);
        end
    end

    // Holds valid until the sample is taken; valid stays high on return.
    task automatic send(input int sel, input logic signed [23:0] v);
        bit ok;
        int n;
        data_in = v;
        if (sel == 0) valid_in = 1'b1;
        else          valid_b  = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok) begin
            @(negedge clk);
            ok = (sel == 0) ? in_ready0 : (in_ready1 & in_ready2);
            @(posedge clk);
            #1;
            n++;
            if (!ok && n >= 50) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: in_ready=0 for %0d cycles, required 1", n);
                ok = 1'b1;
            end
        end
    endtask

    task automatic pixel(input int sel,
                         input logic signed [23:0] v0, v1, v2, v3, v4, v5,
                         input logic [23:0] ea, input logic [23:0] eb);
        logic signed [23:0] v[6];
        v = '{v0, v1, v2, v3, v4, v5};
        if (sel == 0) begin
            q0.push_back('{ea, (exp_pix == 3), -1});
            exp_pix = (exp_pix == 3) ? 0 : exp_pix + 1;
        end else begin
            q1.push_back('{ea, 1'b0, -1});
            q2.push_back('{eb, 1'b0, -1});
        end
        for (int i = 0; i < 6; i++) send(sel, v[i]);
        if (lat_chk) begin
            if (sel == 0) q0[q0.size()-1].cyc = cyc;
            else begin
                q1[q1.size()-1].cyc = cyc;
                q2[q2.size()-1].cyc = cyc;
            end
        end
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        valid_b  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        valid_in = 1'b0;
        valid_b  = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_pix = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; clear = 1'b0; valid_in = 1'b0; valid_b = 1'b0;
        out_ready = 1'b1; data_in = '0;

        // Reset state, with valid_in asserted to confirm nothing is accepted.
        valid_in = 1'b1;
        data_in  = 24'sd77;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_data_out", data_out0, 24'h0);
        check("rst_valid_out", {23'b0, valid_out0}, 24'h0);
        check("rst_frame_done", {23'b0, frame_done0}, 24'h0);
        check("rst_in_ready", {23'b0, in_ready0}, 24'h0);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        rst = 1'b1;

        // Basic sum with latency check; idle cycles catch any extra valid_out.
        pixel(0, 24'sd1, 24'sd2, 24'sd3, 24'sd4, 24'sd5, 24'sd6, 24'd21, 24'd0);
        idle(3);

        // Saturation both directions.
        pixel(0, 24'sh7FFFFF, 24'sh7FFFFF, 24'sh7FFFFF, 24'sh7FFFFF, 24'sh7FFFFF, 24'sh7FFFFF,
              24'h7FFFFF, 24'd0);
        pixel(0, 24'sh800000, 24'sh800000, 24'sh800000, 24'sh800000, 24'sh800000, 24'sh800000,
              24'h800000, 24'd0);
        idle(2);

        // Frame: 30 samples, frame_done only on the 4th pixel.
        pulse_reset();
        pixel(0, 24'sd1, 24'sd1, 24'sd1, 24'sd1, 24'sd1, 24'sd1, 24'd6, 24'd0);
        pixel(0, 24'sd2, 24'sd2, 24'sd2, 24'sd2, 24'sd2, 24'sd2, 24'd12, 24'd0);
        pixel(0, 24'sd3, 24'sd3, 24'sd3, 24'sd3, 24'sd3, 24'sd3, 24'd18, 24'd0);
        pixel(0, 24'sd4, 24'sd4, 24'sd4, 24'sd4, 24'sd4, 24'sd4, 24'd24, 24'd0);
        pixel(0, 24'sd5, 24'sd5, 24'sd5, 24'sd5, 24'sd5, 24'sd5, 24'd30, 24'd0);
        idle(2);

        // Backpressure: result 21 held for 10 cycles while sample 7 waits.
        lat_chk = 1'b0;
        pixel(0, 24'sd1, 24'sd2, 24'sd3, 24'sd4, 24'sd5, 24'sd6, 24'd21, 24'd0);
        lat_chk = 1'b1;
        out_ready = 1'b0;
        data_in   = 24'sd7;
        valid_in  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_in_ready", {23'b0, in_ready0}, 24'h0);
            check("bp_valid_out", {23'b0, valid_out0}, 24'h1);
            check("bp_data_hold", data_out0, 24'd21);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        pixel(0, 24'sd7, 24'sd8, 24'sd9, 24'sd10, 24'sd11, 24'sd12, 24'd57, 24'd0);
        idle(2);

        // Reset mid-pixel discards the partial sum.
        send(0, 24'sd100); send(0, 24'sd100); send(0, 24'sd100);
        pulse_reset();
        pixel(0, 24'sd1, 24'sd2, 24'sd3, 24'sd4, 24'sd5, 24'sd6, 24'd21, 24'd0);
        pixel(0, 24'sd2, 24'sd2, 24'sd2, 24'sd2, 24'sd2, 24'sd2, 24'd12, 24'd0);

        // Clear mid-pixel with a competing sample that must be refused.
        send(0, 24'sd100); send(0, 24'sd100); send(0, 24'sd100);
        clear    = 1'b1;
        data_in  = 24'sd100;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        valid_in = 1'b0;
        exp_pix  = 0;
        pixel(0, 24'sd1, 24'sd2, 24'sd3, 24'sd4, 24'sd5, 24'sd6, 24'd21, 24'd0);
        pixel(0, 24'sd3, 24'sd3, 24'sd3, 24'sd3, 24'sd3, 24'sd3, 24'd18, 24'd0);
        pixel(0, 24'sd4, 24'sd4, 24'sd4, 24'sd4, 24'sd4, 24'sd4, 24'd24, 24'd0);
        pixel(0, 24'sd5, 24'sd5, 24'sd5, 24'sd5, 24'sd5, 24'sd5, 24'd30, 24'd0);
        pixel(0, 24'sd1, 24'sd2, 24'sd3, 24'sd4, 24'sd5, 24'sd6, 24'd21, 24'd0);
        idle(2);

        // Bias 5 without / with ReLU.
        pixel(1, -24'sd10, -24'sd1, 24'sd0, 24'sd0, 24'sd0, 24'sd0, 24'hFFFFFA, 24'h000000);
        pixel(1, 24'sd1, 24'sd2, 24'sd3, 24'sd4, 24'sd5, 24'sd6, 24'd26, 24'd26);
        idle(4);

        check("q0_drained", 24'(q0.size()), 24'd0);
        check("q1_drained", 24'(q1.size()), 24'd0);
        check("q2_drained", 24'(q2.size()), 24'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/featuremap_accum.md
Name: featuremap_accum

Overview:
- Parametrised cross-channel accumulator for conv layers.
- Receives one stream of per-channel conv2d5x5 partial results, channel-interleaved per output pixel: ch0, ch1, …, ch(N_CH-1), then the next pixel.
- Sums N_CH partials, adds a per-feature-map bias, applies an optional ReLU, saturates, and emits one feature-map pixel.
- Successor to the fixed six-channel featuremap wrappers: generalises channel count, width, bias and activation, and adds backpressure and frame tracking.

Parameters:
- DATA_WIDTH, 24, signed two's-complement width of data_in and data_out (fixed-point; this block does not shift the binary point).
- N_CH, 6, number of channel partials per output pixel; must be ≥1.
- BIAS, 0, signed DATA_WIDTH-bit raw bias added once per pixel.
- ACT_MODE, 0, activation: 0 = none, 1 = ReLU.
- FRAME_PIXELS, 576, output pixels per frame; must be ≥1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-low.
- clear  input  1  synchronous flush of partial accumulation and pixel counter.
- data_in  input  DATA_WIDTH  signed channel partial.
- valid_in  input  1  data_in valid.
- in_ready  output  1  block accepts data_in this cycle.
- data_out  output  DATA_WIDTH  signed result pixel.
- valid_out  output  1  data_out valid.
- out_ready  input  1  downstream accepts data_out.
- frame_done  output  1  high with valid_out on the last pixel of a frame.

Behaviour:
- Reset is synchronous and active-low: while rst=0 at a clock edge, data_out=0, valid_out=0, frame_done=0, ch_cnt=0, pix_cnt=0, acc=0. in_ready is forced 0 while rst=0.
- in_ready = rst & ~(valid_out & ~out_ready), combinational. Transfer in: valid_in & in_ready. Transfer out: valid_out & out_ready.
- The accumulator acc is DATA_WIDTH+clog2(N_CH)+1 bits signed. All inputs and BIAS are sign-extended before addition; no intermediate overflow is allowed.
- On an input transfer with ch_cnt < N_CH-1:
  - acc <= (ch_cnt==0 ? x : acc+x);
  - ch_cnt++.
- On an input transfer with ch_cnt == N_CH-1 (for N_CH=1, every transfer):
  - sum = (N_CH==1 ? x : acc+x) + BIAS;
  - if ACT_MODE==1 and sum<0, sum=0;
  - saturate sum to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1];
  - data_out <= sum, valid_out <= 1, ch_cnt <= 0;
  - frame_done <= (pix_cnt==FRAME_PIXELS-1);
  - pix_cnt <= (pix_cnt==FRAME_PIXELS-1 ? 0 : pix_cnt+1).
- Latency: data_out is valid on the cycle after the last channel transfer. Throughput is one pixel per N_CH accepted samples, with no bubbles when out_ready=1.
- Output register:
  - If there is an output transfer and no new result this cycle, valid_out <= 0 and frame_done <= 0.
  - A new result in the same cycle as an output transfer overwrites the register, and valid_out stays 1.
  - data_out and frame_done hold stable while valid_out & ~out_ready.
- Stall: while valid_out & ~out_ready, no input is accepted. Partial acc and ch_cnt hold.
- clear=1 (with rst=1):
  - ch_cnt <= 0, pix_cnt <= 0; the partial sum is discarded.
  - Has priority over a simultaneous valid_in; that sample is not accepted, so in_ready is treated as 0 for it.
  - A pending valid_out, data_out and frame_done is not affected.
- Channel counter wraps N_CH-1 → 0. Pixel counter wraps FRAME_PIXELS-1 → 0.
- Reset mid-pixel: the partial sum is lost, and the next accepted sample is channel 0.

Test Plan:
- Sum: N_CH=6, BIAS=0, ACT_MODE=0, out_ready=1. Feed 1,2,3,4,5,6 back-to-back → data_out=21 with valid_out for exactly 1 cycle, one cycle after sample 6.
- Bias/ReLU: BIAS=5, inputs -10,-1,0,0,0,0.
  - ACT_MODE=0 → data_out=-6 (0xFFFFFA).
  - ACT_MODE=1 → data_out=0.
- Saturation: six samples of 0x7FFFFF → 0x7FFFFF. Six samples of 0x800000 → 0x800000.
- Backpressure: out_ready=0 after the first result with valid_in held high.
  - in_ready=0 and data_out holds 21 for 10 cycles.
  - Raise out_ready → the next 6 samples (7..12) are accepted with none lost → data_out=57.
- Frame: FRAME_PIXELS=4, feed 30 samples → frame_done=1 only with the 4th valid_out. The 5th pixel has frame_done=0.
- Reset/clear mid-pixel: feed 3 samples (100 each), then either rst=0 for 1 cycle or clear=1 with valid_in=1. Then feed 1..6 → data_out=21 with no stale contribution. After clear, pix_cnt restarts, so frame_done appears on the 4th subsequent pixel (FRAME_PIXELS=4).
